// File: rtl/vx_pkg.sv
// Shared video-memory constants and CPU access FSM encoding.
// Used by the arbiter, its CPU sub-block and the shift-register stage (VLAT).
package vx_pkg;

   localparam int unsigned AW   = 6;
   localparam int unsigned DW   = 4;
   localparam int unsigned VGAP = 4;
   localparam int unsigned VLAT = 3;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_MEM  = 2'd1,
      C_WAIT = 2'd2,
      C_ACK  = 2'd3
   } cpu_state_t;

endpackage

// File: rtl/vmem_arbiter_if.sv
// Video fetch, CPU bus and memory-side signals of the video memory arbiter.
// slave = arbiter view, master = surrounding pipeline/CPU/memory view.
interface vmem_arbiter_if
   import vx_pkg::*;
#(
   parameter int unsigned AW = vx_pkg::AW,
   parameter int unsigned DW = vx_pkg::DW
);

   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          vid_ovr;

   logic          cpu_stb;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  vid_req, vid_addr, cpu_stb, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_data, vid_valid, vid_ovr, cpu_rdata, cpu_ack,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output vid_req, vid_addr, cpu_stb, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_data, vid_valid, vid_ovr, cpu_rdata, cpu_ack,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/vmem_arb_cpu.sv
// CPU access sequencer: tracks one granted access through issue, memory
// latency and the acknowledge cycle; returns read data with cpu_ack.
module vmem_arb_cpu
   import vx_pkg::*;
#(
   parameter int unsigned DW = vx_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          grant,
   input  logic          cpu_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          idle_c,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack
);

   cpu_state_t    state_q, state_d;
   logic          we_q, we_d;
   logic          ack_d;
   logic [DW-1:0] rdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= C_IDLE;
         we_q      <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         cpu_ack   <= ack_d;
         cpu_rdata <= rdata_d;
      end
   end

   // Direction is latched at grant so a master dropping cpu_we early cannot corrupt capture.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      ack_d   = 1'b0;
      rdata_d = cpu_rdata;
      unique case (state_q)
         C_IDLE: begin
            if (grant) begin
               state_d = C_MEM;
               we_d    = cpu_we;
            end
         end
         C_MEM:  state_d = C_WAIT;
         C_WAIT: begin
            state_d = C_ACK;
            ack_d   = 1'b1;
            if (!we_q) rdata_d = mem_rdata;
         end
         C_ACK:   state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   assign idle_c = (state_q == C_IDLE);

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port video memory arbiter: video fetches own any slot they request
// with fixed 3-cycle latency; the CPU gets the remaining slots.
module vmem_arbiter
   import vx_pkg::*;
#(
   parameter int unsigned VGAP = vx_pkg::VGAP
) (
   input logic           clk,
   input logic           rst,
   vmem_arbiter_if.slave bus
);

   localparam int unsigned CW = ($clog2(VGAP + 1) < 2) ? 2 : $clog2(VGAP + 1);

   logic          cpu_idle_c;
   logic          cpu_grant_c;
   logic          vtag1_q, vtag2_q;
   logic [CW-1:0] gap_q;

   assign cpu_grant_c = cpu_idle_c & bus.cpu_stb & ~bus.vid_req;

   // Slot selection: video always wins, address/data hold on idle slots.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else if (bus.vid_req) begin
         bus.mem_en    <= 1'b1;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= bus.vid_addr;
      end else if (cpu_grant_c) begin
         bus.mem_en    <= 1'b1;
         bus.mem_we    <= bus.cpu_we;
         bus.mem_addr  <= bus.cpu_addr;
         bus.mem_wdata <= bus.cpu_wdata;
      end else begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
      end
   end

   // Video tag pipeline: the read issued one cycle after vid_req returns one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vtag1_q       <= 1'b0;
         vtag2_q       <= 1'b0;
         bus.vid_valid <= 1'b0;
         bus.vid_data  <= '0;
      end else begin
         vtag1_q       <= bus.vid_req;
         vtag2_q       <= vtag1_q;
         bus.vid_valid <= vtag2_q;
         if (vtag2_q) bus.vid_data <= bus.mem_rdata;
      end
   end

   // Request spacing monitor; starts saturated so the first request is never an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_q       <= CW'(VGAP);
         bus.vid_ovr <= 1'b0;
      end else if (bus.vid_req) begin
         gap_q <= '0;
         if (gap_q < CW'(VGAP - 1)) bus.vid_ovr <= 1'b1;
      end else if (gap_q != CW'(VGAP)) begin
         gap_q <= gap_q + CW'(1);
      end
   end

   vmem_arb_cpu u_cpu (
      .clk       (clk),
      .rst       (rst),
      .grant     (cpu_grant_c),
      .cpu_we    (bus.cpu_we),
      .mem_rdata (bus.mem_rdata),
      .idle_c    (cpu_idle_c),
      .cpu_rdata (bus.cpu_rdata),
      .cpu_ack   (bus.cpu_ack)
   );

endmodule
